// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rob_pkg
// Description : Shared sizing constants and the entry record for the
//               reorder buffer.
//               DEPTH  - number of entries (power of two, >= 4)
//               TAG_W  - width of an entry tag
//               XLEN   - width of a result value
//               rob_entry_t - one buffer slot {valid, done, has_rd, rd, value}
// Revision    : 1.0 - initial release
// ============================================================================
package rob_pkg;

  localparam int DEPTH = 8;
  localparam int TAG_W = $clog2(DEPTH);
  localparam int XLEN  = 32;

  typedef struct packed {
    logic            valid;
    logic            done;
    logic            has_rd;
    logic [4:0]      rd;
    logic [XLEN-1:0] value;
  } rob_entry_t;

endpackage
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer
// Description : Circular reorder buffer. Two in-order allocations per cycle,
//               two out-of-order writebacks by tag, two in-order retirements.
// Ports       :
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset
//   flush         in   discard all entries
//   disp_valid    in   [1:0] dispatch request per slot (slot 0 older)
//   disp_has_rd   in   [1:0] instruction writes a destination register
//   disp_rd       in   [1:0][4:0] destination register
//   disp_ready    out  room for two dispatches this cycle
//   disp_tag      out  [1:0][TAG_W-1:0] tag assigned to each slot
//   wb_valid      in   [1:0] writeback request per port
//   wb_tag        in   [1:0][TAG_W-1:0] entry being completed
//   wb_value      in   [1:0][XLEN-1:0] result value
//   commit_valid  out  [1:0] slot retires at this edge (slot 0 older)
//   commit_has_rd out  [1:0] retiring instruction writes a register
//   commit_rd     out  [1:0][4:0] retiring destination register
//   commit_value  out  [1:0][XLEN-1:0] retiring result value
//   count         out  [TAG_W:0] occupied entries
// Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
  parameter int DEPTH = rob_pkg::DEPTH,
  parameter int TAG_W = $clog2(DEPTH),
  parameter int XLEN  = rob_pkg::XLEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [1:0]                 disp_valid,
  input  logic [1:0]                 disp_has_rd,
  input  logic [1:0][4:0]            disp_rd,
  output logic                       disp_ready,
  output logic [1:0][TAG_W-1:0]      disp_tag,
  input  logic [1:0]                 wb_valid,
  input  logic [1:0][TAG_W-1:0]      wb_tag,
  input  logic [1:0][XLEN-1:0]       wb_value,
  output logic [1:0]                 commit_valid,
  output logic [1:0]                 commit_has_rd,
  output logic [1:0][4:0]            commit_rd,
  output logic [1:0][XLEN-1:0]       commit_value,
  output logic [TAG_W:0]             count
);

  import rob_pkg::*;

  localparam logic [TAG_W:0] c_READY_MAX = (TAG_W+1)'(DEPTH - 2);

  rob_entry_t       ent_q [DEPTH];
  rob_entry_t       ent_d [DEPTH];
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  logic [TAG_W-1:0] head_p1, tail_p1;
  logic             alloc0, alloc1, ret0, ret1;

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  assign head_p1 = head_q + TAG_W'(1);
  assign tail_p1 = tail_q + TAG_W'(1);

  assign disp_ready  = (count_q <= c_READY_MAX);
  assign disp_tag[0] = tail_q;
  assign disp_tag[1] = tail_p1;

  // Slot 1 only ever allocates behind slot 0 so program order is kept.
  assign alloc0 = disp_ready & disp_valid[0];
  assign alloc1 = alloc0 & disp_valid[1];

  // Commit is suppressed while the buffer is being cleared.
  assign ret0 = ent_q[head_q].valid & ent_q[head_q].done & ~flush & ~rst;
  assign ret1 = ret0 & ent_q[head_p1].valid & ent_q[head_p1].done;

  assign commit_valid     = {ret1, ret0};
  assign commit_has_rd[0] = ent_q[head_q].has_rd;
  assign commit_has_rd[1] = ent_q[head_p1].has_rd;
  assign commit_rd[0]     = ent_q[head_q].rd;
  assign commit_rd[1]     = ent_q[head_p1].rd;
  assign commit_value[0]  = ent_q[head_q].value;
  assign commit_value[1]  = ent_q[head_p1].value;
  assign count            = count_q;

  always_comb begin
    ent_d = ent_q;

    // Port 1 is applied last so it wins a same-tag collision. Validity is
    // judged on start-of-cycle state, so a tag allocated this cycle is immune.
    for (int p = 0; p < 2; p++) begin
      if (wb_valid[p] && ent_q[wb_tag[p]].valid) begin
        ent_d[wb_tag[p]].done  = 1'b1;
        ent_d[wb_tag[p]].value = wb_value[p];
      end
    end

    if (ret0) ent_d[head_q]  = '0;
    if (ret1) ent_d[head_p1] = '0;

    if (alloc0) ent_d[tail_q]  = '{valid: 1'b1, done: 1'b0, has_rd: disp_has_rd[0],
                                   rd: disp_rd[0], value: '0};
    if (alloc1) ent_d[tail_p1] = '{valid: 1'b1, done: 1'b0, has_rd: disp_has_rd[1],
                                   rd: disp_rd[1], value: '0};

    head_d  = head_q + TAG_W'(ret0) + TAG_W'(ret1);
    tail_d  = tail_q + TAG_W'(alloc0) + TAG_W'(alloc1);
    count_d = count_q + (TAG_W+1)'(alloc0) + (TAG_W+1)'(alloc1)
                      - (TAG_W+1)'(ret0)   - (TAG_W+1)'(ret1);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reorder_buffer
// Description : Directed, table-driven bench for reorder_buffer (DEPTH=8).
//               Each table row is one clock cycle: the inputs driven in that
//               cycle and the outputs expected before its rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;

  localparam int TAG_W = 3;
  localparam int XLEN  = 32;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic [1:0]            disp_valid;
  logic [1:0]            disp_has_rd;
  logic [1:0][4:0]       disp_rd;
  logic                  disp_ready;
  logic [1:0][TAG_W-1:0] disp_tag;
  logic [1:0]            wb_valid;
  logic [1:0][TAG_W-1:0] wb_tag;
  logic [1:0][XLEN-1:0]  wb_value;
  logic [1:0]            commit_valid;
  logic [1:0]            commit_has_rd;
  logic [1:0][4:0]       commit_rd;
  logic [1:0][XLEN-1:0]  commit_value;
  logic [TAG_W:0]        count;

  reorder_buffer #(.DEPTH(8), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .disp_valid   (disp_valid),
    .disp_has_rd  (disp_has_rd),
    .disp_rd      (disp_rd),
    .disp_ready   (disp_ready),
    .disp_tag     (disp_tag),
    .wb_valid     (wb_valid),
    .wb_tag       (wb_tag),
    .wb_value     (wb_value),
    .commit_valid (commit_valid),
    .commit_has_rd(commit_has_rd),
    .commit_rd    (commit_rd),
    .commit_value (commit_value),
    .count        (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic [1:0]  dv;
    logic [1:0]  dhr;
    logic [4:0]  rd0, rd1;
    logic [1:0]  wbv;
    logic [2:0]  wt0, wt1;
    logic [31:0] wv0, wv1;
    logic        e_rdy;
    logic [2:0]  e_t0;
    logic [3:0]  e_cnt;
    logic [1:0]  e_cv;
    logic [1:0]  e_chr;
    logic [4:0]  e_rd0, e_rd1;
    logic [31:0] e_v0, e_v1;
  } vec_t;

  vec_t vecs [33];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    flush = 1'b0; disp_valid = '0; disp_has_rd = '0; disp_rd = '0;
    wb_valid = '0; wb_tag = '0; wb_value = '0;
  endtask

  initial begin
    //          fl dv dhr rd0 rd1 wbv wt0 wt1 wv0    wv1     rdy t0 cnt cv chr erd0 erd1 ev0    ev1
    vecs[0]  = '{0, 0, 0,  0,  0,  0,  0,  0,  0,     0,      1,  0, 0,  0, 0,  0,  0,  0,     0};
    vecs[1]  = '{0, 3, 3,  1,  2,  0,  0,  0,  0,     0,      1,  0, 0,  0, 0,  0,  0,  0,     0};
    vecs[2]  = '{0, 0, 0,  0,  0,  3,  1,  0,  'h22,  'h11,   1,  2, 2,  0, 0,  0,  0,  0,     0};
    vecs[3]  = '{0, 0, 0,  0,  0,  0,  0,  0,  0,     0,      1,  2, 2,  3, 3,  1,  2,  'h11,  'h22};
    vecs[4]  = '{0, 0, 0,  0,  0,  0,  0,  0,  0,     0,      1,  2, 0,  0, 0,  0,  0,  0,     0};
    vecs[5]  = '{0, 3, 1,  3,  4,  0,  0,  0,  0,     0,      1,  2, 0,  0, 0,  0,  0,  0,     0};
    vecs[6]  = '{0, 3, 3,  5,  6,  0,  0,  0,  0,     0,      1,  4, 2,  0, 0,  0,  0,  0,     0};
    vecs[7]  = '{0, 0, 0,  0,  0,  1,  5,  0,  'h55,  0,      1,  6, 4,  0, 0,  0,  0,  0,     0};
    vecs[8]  = '{0, 0, 0,  0,  0,  0,  0,  0,  0,     0,      1,  6, 4,  0, 0,  0,  0,  0,     0};
    vecs[9]  = '{0, 0, 0,  0,  0,  2,  0,  2,  0,     'h33,   1,  6, 4,  0, 0,  0,  0,  0,     0};
    vecs[10] = '{0, 0, 0,  0,  0,  0,  0,  0,  0,     0,      1,  6, 4,  1, 1,  3,  0,  'h33,  0};
    vecs[11] = '{0, 0, 0,  0,  0,  3,  3,  4,  'h44,  'h45,   1,  6, 3,  0, 0,  0,  0,  0,     0};
    vecs[12] = '{0, 0, 0,  0,  0,  0,  0,  0,  0,     0,      1,  6, 3,  3, 2,  4,  5,  'h44,  'h45};
    vecs[13] = '{0, 0, 0,  0,  0,  0,  0,  0,  0,     0,      1,  6, 1,  1, 1,  6,  0,  'h55,  0};
    vecs[14] = '{0, 3, 3,  7,  8,  0,  0,  0,  0,     0,      1,  6, 0,  0, 0,  0,  0,  0,     0};
    vecs[15] = '{0, 3, 3,  9,  10, 0,  0,  0,  0,     0,      1,  0, 2,  0, 0,  0,  0,  0,     0};
    vecs[16] = '{0, 3, 3,  11, 12, 0,  0,  0,  0,     0,      1,  2, 4,  0, 0,  0,  0,  0,     0};
    vecs[17] = '{0, 3, 3,  13, 14, 0,  0,  0,  0,     0,      1,  4, 6,  0, 0,  0,  0,  0,     0};
    vecs[18] = '{0, 3, 3,  15, 16, 0,  0,  0,  0,     0,      0,  6, 8,  0, 0,  0,  0,  0,     0};
    vecs[19] = '{0, 0, 0,  0,  0,  3,  6,  7,  'h66,  'h77,   0,  6, 8,  0, 0,  0,  0,  0,     0};
    vecs[20] = '{0, 0, 0,  0,  0,  0,  0,  0,  0,     0,      0,  6, 8,  3, 3,  7,  8,  'h66,  'h77};
    vecs[21] = '{0, 0, 0,  0,  0,  1,  6,  0,  'hAA,  0,      1,  6, 6,  0, 0,  0,  0,  0,     0};
    vecs[22] = '{0, 2, 3,  17, 18, 0,  0,  0,  0,     0,      1,  6, 6,  0, 0,  0,  0,  0,     0};
    vecs[23] = '{0, 1, 1,  20, 0,  0,  0,  0,  0,     0,      1,  6, 6,  0, 0,  0,  0,  0,     0};
    vecs[24] = '{0, 0, 0,  0,  0,  3,  0,  0,  'hB0,  'hB1,   0,  7, 7,  0, 0,  0,  0,  0,     0};
    vecs[25] = '{0, 0, 0,  0,  0,  0,  0,  0,  0,     0,      0,  7, 7,  1, 1,  9,  0,  'hB1,  0};
    vecs[26] = '{0, 0, 0,  0,  0,  3,  1,  2,  1,     2,      1,  7, 6,  0, 0,  0,  0,  0,     0};
    vecs[27] = '{0, 0, 0,  0,  0,  3,  3,  4,  3,     4,      1,  7, 6,  3, 3,  10, 11, 1,     2};
    vecs[28] = '{0, 0, 0,  0,  0,  1,  5,  0,  5,     0,      1,  7, 4,  3, 3,  12, 13, 3,     4};
    vecs[29] = '{0, 3, 3,  21, 22, 0,  0,  0,  0,     0,      1,  7, 2,  1, 1,  14, 0,  5,     0};
    vecs[30] = '{0, 3, 3,  23, 24, 1,  6,  0,  'h99,  0,      1,  1, 3,  0, 0,  0,  0,  0,     0};
    vecs[31] = '{1, 3, 3,  25, 26, 0,  0,  0,  0,     0,      1,  3, 5,  0, 0,  0,  0,  0,     0};
    vecs[32] = '{0, 0, 0,  0,  0,  0,  0,  0,  0,     0,      1,  0, 0,  0, 0,  0,  0,  0,     0};

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_count",        32'(count),        0);
    chk("reset_ready",        32'(disp_ready),   1);
    chk("reset_commit_value", commit_value[0],   0);
    chk("reset_commit_rd",    32'(commit_rd[0]), 0);

    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      flush          = vecs[i].fl;
      disp_valid     = vecs[i].dv;
      disp_has_rd    = vecs[i].dhr;
      disp_rd[0]     = vecs[i].rd0;
      disp_rd[1]     = vecs[i].rd1;
      wb_valid       = vecs[i].wbv;
      wb_tag[0]      = vecs[i].wt0;
      wb_tag[1]      = vecs[i].wt1;
      wb_value[0]    = vecs[i].wv0;
      wb_value[1]    = vecs[i].wv1;
      #1;
      chk($sformatf("v%0d_count", i),  32'(count),        32'(vecs[i].e_cnt));
      chk($sformatf("v%0d_ready", i),  32'(disp_ready),   32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_tag0", i),   32'(disp_tag[0]),  32'(vecs[i].e_t0));
      chk($sformatf("v%0d_tag1", i),   32'(disp_tag[1]),  32'(3'(vecs[i].e_t0 + 3'd1)));
      chk($sformatf("v%0d_cvalid", i), 32'(commit_valid), 32'(vecs[i].e_cv));
      if (vecs[i].e_cv[0]) begin
        chk($sformatf("v%0d_c0_value", i), commit_value[0],      vecs[i].e_v0);
        chk($sformatf("v%0d_c0_rd", i),    32'(commit_rd[0]),     32'(vecs[i].e_rd0));
        chk($sformatf("v%0d_c0_hasrd", i), 32'(commit_has_rd[0]), 32'(vecs[i].e_chr[0]));
      end
      if (vecs[i].e_cv[1]) begin
        chk($sformatf("v%0d_c1_value", i), commit_value[1],      vecs[i].e_v1);
        chk($sformatf("v%0d_c1_rd", i),    32'(commit_rd[1]),     32'(vecs[i].e_rd1));
        chk($sformatf("v%0d_c1_hasrd", i), 32'(commit_has_rd[1]), 32'(vecs[i].e_chr[1]));
      end
    end

    // Reset arriving while a completed entry sits at head: commit must be
    // masked in that cycle and the buffer must come back empty.
    @(negedge clk);
    idle_inputs();
    disp_valid = 2'b01; disp_has_rd = 2'b01; disp_rd[0] = 5'd30;
    #1;
    chk("rst_seq_tag0", 32'(disp_tag[0]), 0);
    @(negedge clk);
    idle_inputs();
    wb_valid = 2'b01; wb_tag[0] = 3'd0; wb_value[0] = 32'hC0;
    #1;
    chk("rst_seq_no_bypass", 32'(commit_valid), 0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("rst_seq_cvalid", 32'(commit_valid), 1);
    chk("rst_seq_cvalue", commit_value[0],   32'hC0);
    chk("rst_seq_crd",    32'(commit_rd[0]), 30);
    rst = 1'b1;
    #1;
    chk("rst_seq_masked", 32'(commit_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_seq_count", 32'(count),        0);
    chk("rst_seq_tag",   32'(disp_tag[0]),  0);
    chk("rst_seq_cv",    32'(commit_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
